// File: rtl/vic20_loader_pkg.sv
// Shared constants and types for the PRG/CRT download loader.
// Holds the FSM encoding, file-type indices and the BASIC pointer injection table.
package vic20_loader_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned INJ_N  = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HDR_LO = 3'd1;
  localparam state_t ST_HDR_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_INJECT = 3'd4;

  localparam logic [IDX_W-1:0] IDX_PRG = 5'd1;
  localparam logic [IDX_W-1:0] IDX_CRT = 5'd2;

  localparam logic [ADDR_W-1:0] CRT_DEFAULT_BASE = 16'hA000;

  // One injected write: target address and whether it carries the high byte.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              hi;
  } inj_entry_t;

  // BASIC start-of-variables / arrays / end-of-arrays pointers, then the load-end pointer.
  localparam inj_entry_t INJ_TABLE [INJ_N] = '{
    '{addr: 16'h002D, hi: 1'b0},
    '{addr: 16'h002E, hi: 1'b1},
    '{addr: 16'h002F, hi: 1'b0},
    '{addr: 16'h0030, hi: 1'b1},
    '{addr: 16'h0031, hi: 1'b0},
    '{addr: 16'h0032, hi: 1'b1},
    '{addr: 16'h00AE, hi: 1'b0},
    '{addr: 16'h00AF, hi: 1'b1}
  };

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_beat_t;

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return (idx == IDX_PRG) || (idx == IDX_CRT);
  endfunction

endpackage

// File: rtl/prg_loader_if.sv
// Download stream in, addressed memory writes out, plus loader status.
// master drives the ioctl side; slave is the loader.
interface prg_loader_if;

  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        crt_load_addr;

  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic [15:0] end_addr;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, crt_load_addr,
    input  mem_wr, mem_addr, mem_data, busy, end_addr
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, crt_load_addr,
    output mem_wr, mem_addr, mem_data, busy, end_addr
  );

endinterface

// File: rtl/prg_ptr_injector.sv
// Walks the 8-entry BASIC pointer table while enabled, one strobe every INJECT_GAP cycles.
// Counters clear whenever disabled so each injection run starts at entry 0 immediately.
module prg_ptr_injector #(
  parameter int unsigned INJECT_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] end_addr,
  output logic        strobe_c,
  output logic        last_c,
  output logic [15:0] addr_c,
  output logic [7:0]  data_c
);
  import vic20_loader_pkg::*;

  localparam int unsigned GAP_W = (INJECT_GAP > 1) ? $clog2(INJECT_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(INJECT_GAP - 1);

  logic [2:0]       idx;
  logic [GAP_W-1:0] gap;
  inj_entry_t       ent;

  always_comb begin
    ent      = INJ_TABLE[idx];
    strobe_c = en && (gap == '0);
    last_c   = strobe_c && (idx == 3'd7);
    addr_c   = ent.addr;
    data_c   = ent.hi ? end_addr[15:8] : end_addr[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      gap <= '0;
    end else if (!en) begin
      idx <= '0;
      gap <= '0;
    end else if (gap == '0) begin
      idx <= idx + 3'd1;
      gap <= GAP_RELOAD;
    end else begin
      gap <= gap - GAP_W'(1);
    end
  end

endmodule

// File: rtl/prg_loader.sv
// PRG/CRT download parser: strips the load-address header, emits one write per payload
// byte and, after a PRG, injects the BASIC pointers so RUN works straight away.
module prg_loader #(
  parameter int unsigned INJECT_GAP = 2
) (
  input  logic         clk_sys,
  input  logic         reset,
  prg_loader_if.slave  bus
);
  import vic20_loader_pkg::*;

  state_t      state, state_n;
  logic [15:0] ptr, ptr_n;
  logic        dl_q;
  logic        is_prg, is_prg_n;
  logic        busy_q, busy_n;
  logic        mem_wr_q, wr_n;
  mem_beat_t   beat_q, beat_n;
  logic [15:0] end_addr_q;

  logic        rise, fall, accept, start;
  logic        inj_en, inj_strobe, inj_last;
  logic [15:0] inj_addr;
  logic [7:0]  inj_data;

  logic unused_bits;
  assign unused_bits = ^{bus.ioctl_addr, bus.ioctl_index[7:5]};

  // Edge detect on the registered copy; the cycle the fall is seen still accepts a trailing byte.
  assign rise   = bus.ioctl_download & ~dl_q;
  assign fall   = ~bus.ioctl_download & dl_q;
  assign accept = bus.ioctl_wr & (bus.ioctl_download | dl_q);
  assign start  = rise & idx_valid(bus.ioctl_index[4:0]);
  assign inj_en = (state == ST_INJECT);

  prg_ptr_injector #(.INJECT_GAP(INJECT_GAP)) u_injector (
    .clk      (clk_sys),
    .rst      (reset),
    .en       (inj_en),
    .end_addr (end_addr_q),
    .strobe_c (inj_strobe),
    .last_c   (inj_last),
    .addr_c   (inj_addr),
    .data_c   (inj_data)
  );

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    is_prg_n = is_prg;
    busy_n   = busy_q;
    wr_n     = 1'b0;
    beat_n   = beat_q;

    case (state)
      ST_HDR_LO: begin
        if (accept) begin
          ptr_n[7:0] = bus.ioctl_dout;
          busy_n     = 1'b1;
          state_n    = ST_HDR_HI;
        end
        if (fall) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          ptr_n[15:8] = bus.ioctl_dout;
          busy_n      = 1'b1;
          state_n     = ST_DATA;
        end
        if (fall) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
      ST_DATA: begin
        if (accept) begin
          wr_n   = 1'b1;
          beat_n = '{addr: ptr, data: bus.ioctl_dout};
          ptr_n  = ptr + 16'd1;
          busy_n = 1'b1;
        end
        if (fall) begin
          if (is_prg) begin
            state_n = ST_INJECT;
          end else begin
            state_n = ST_IDLE;
            busy_n  = wr_n;
          end
        end
      end
      ST_INJECT: begin
        if (inj_strobe) begin
          wr_n   = 1'b1;
          beat_n = '{addr: inj_addr, data: inj_data};
        end
        // Stay busy through the final write; IDLE clears it on the following cycle.
        if (inj_last) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase

    // A new file starts from IDLE or pre-empts any injection still in flight.
    if (start && ((state == ST_IDLE) || (state == ST_INJECT))) begin
      is_prg_n = (bus.ioctl_index[4:0] == IDX_PRG);
      wr_n     = 1'b0;
      beat_n   = beat_q;
      busy_n   = 1'b0;
      if (is_prg_n || bus.crt_load_addr) begin
        state_n = ST_HDR_LO;
      end else begin
        ptr_n   = CRT_DEFAULT_BASE;
        state_n = ST_DATA;
      end
    end
  end

  // dl_q resets high so a download already in progress at reset release is not a rising edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      dl_q       <= 1'b1;
      is_prg     <= 1'b0;
      busy_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      beat_q     <= '0;
      end_addr_q <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      dl_q       <= bus.ioctl_download;
      is_prg     <= is_prg_n;
      busy_q     <= busy_n;
      mem_wr_q   <= wr_n;
      beat_q     <= beat_n;
      end_addr_q <= ptr_n;
    end
  end

  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = beat_q.addr;
  assign bus.mem_data = beat_q.data;
  assign bus.busy     = busy_q;
  assign bus.end_addr = end_addr_q;

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: PRG/CRT parsing, wrap, edge cases, injection timing, reset.
module tb_prg_loader;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  prg_loader_if bus ();

  prg_loader #(.INJECT_GAP(2)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fall_cyc    = 0;
  int busy_fall_cyc;
  logic busy_prev = 1'b0;

  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          log_cyc  [$];

  logic [15:0] inj_addr [8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030,
                                16'h0031, 16'h0032, 16'h00AE, 16'h00AF};

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Write log and busy-fall timestamp, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (bus.mem_wr) begin
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_data);
        log_cyc.push_back(cyc);
      end
      if (busy_prev && !bus.busy) busy_fall_cyc <= cyc;
      busy_prev <= bus.busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int obs_cyc(input int k);
    return (k < log_cyc.size()) ? log_cyc[k] : -100;
  endfunction

  task automatic exp_write(input int k, input logic [15:0] a, input logic [7:0] d);
    check($sformatf("wr%0d_addr", k),
          (k < log_addr.size()) ? {16'h0, log_addr[k]} : 32'hFFFF_FFFF, {16'h0, a});
    check($sformatf("wr%0d_data", k),
          (k < log_data.size()) ? {24'h0, log_data[k]} : 32'hFFFF_FFFF, {24'h0, d});
  endtask

  task automatic exp_inject(input int base, input logic [15:0] e);
    for (int i = 0; i < 8; i++)
      exp_write(base + i, inj_addr[i], (i % 2 == 1) ? e[15:8] : e[7:0]);
    check("inj_first_cyc", 32'(obs_cyc(base)), 32'(fall_cyc + 2));
    for (int i = 1; i < 8; i++)
      check($sformatf("inj_gap%0d", i), 32'(obs_cyc(base + i) - obs_cyc(base + i - 1)), 32'd2);
    check("busy_drop_cyc", 32'(busy_fall_cyc), 32'(obs_cyc(base + 7) + 1));
  endtask

  // Streams n bytes (first byte in the most significant position of v), then drops download.
  task automatic load_file(input logic [7:0] idx, input logic crt, input logic [63:0] v,
                           input int n, input bit burst);
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.crt_load_addr  = crt;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < n; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_dout = v[8*(n-1-i) +: 8];
      bus.ioctl_addr = 16'(i);
      @(negedge clk_sys);
      if (!burst) begin
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
      end
    end
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    fall_cyc = cyc;
  endtask

  initial begin
    int t;
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 16'd0;
    bus.ioctl_dout     = 8'd0;
    bus.crt_load_addr  = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_mem_wr",   32'(bus.mem_wr),   32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_end_addr", 32'(bus.end_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("idle_mem_wr", 32'(bus.mem_wr), 32'd0);

    // PRG 01 10 AA BB CC
    load_file(8'd1, 1'b0, 64'h0110AABBCC, 5, 1'b0);
    repeat (40) @(negedge clk_sys);
    check("prg_count", 32'(log_addr.size()), 32'd11);
    exp_write(0, 16'h1001, 8'hAA);
    exp_write(1, 16'h1002, 8'hBB);
    exp_write(2, 16'h1003, 8'hCC);
    exp_inject(3, 16'h1004);
    check("prg_end_addr", 32'(bus.end_addr), 32'h1004);
    check("prg_busy_idle", 32'(bus.busy), 32'd0);

    // CRT headerless at $A000
    load_file(8'd2, 1'b0, 64'h1122, 2, 1'b0);
    repeat (20) @(negedge clk_sys);
    check("crt0_count", 32'(log_addr.size()), 32'd2);
    exp_write(0, 16'hA000, 8'h11);
    exp_write(1, 16'hA001, 8'h22);
    check("crt0_end_addr", 32'(bus.end_addr), 32'hA002);
    check("crt0_busy_drop", 32'(busy_fall_cyc), 32'(fall_cyc + 1));

    // CRT with load address header
    load_file(8'd2, 1'b1, 64'h006055, 3, 1'b0);
    repeat (20) @(negedge clk_sys);
    check("crt1_count", 32'(log_addr.size()), 32'd1);
    exp_write(0, 16'h6000, 8'h55);
    check("crt1_end_addr", 32'(bus.end_addr), 32'h6001);
    check("crt1_busy_drop", 32'(busy_fall_cyc), 32'(fall_cyc + 1));

    // Address wrap
    load_file(8'd1, 1'b0, 64'hFFFF0102, 4, 1'b0);
    repeat (40) @(negedge clk_sys);
    check("wrap_count", 32'(log_addr.size()), 32'd10);
    exp_write(0, 16'hFFFF, 8'h01);
    exp_write(1, 16'h0000, 8'h02);
    check("wrap_end_addr", 32'(bus.end_addr), 32'h0001);
    exp_inject(2, 16'h0001);

    // 1-byte PRG and invalid index produce nothing
    load_file(8'd1, 1'b0, 64'h01, 1, 1'b0);
    repeat (30) @(negedge clk_sys);
    check("short_count", 32'(log_addr.size()), 32'd0);
    check("short_busy", 32'(bus.busy), 32'd0);
    load_file(8'd0, 1'b0, 64'h00100102, 4, 1'b0);
    repeat (30) @(negedge clk_sys);
    check("idx0_count", 32'(log_addr.size()), 32'd0);
    check("idx0_busy", 32'(bus.busy), 32'd0);

    // Back-to-back strobes including the header
    load_file(8'd1, 1'b0, 64'h00201011121314, 7, 1'b1);
    repeat (40) @(negedge clk_sys);
    check("b2b_count", 32'(log_addr.size()), 32'd13);
    for (int i = 0; i < 5; i++) exp_write(i, 16'h2000 + 16'(i), 8'h10 + 8'(i));
    for (int i = 1; i < 5; i++)
      check($sformatf("b2b_cyc%0d", i), 32'(obs_cyc(i) - obs_cyc(i - 1)), 32'd1);
    exp_inject(5, 16'h2005);

    // Reset during the third injected write
    load_file(8'd1, 1'b0, 64'h003077, 3, 1'b0);
    t = 0;
    while (!(bus.mem_wr && bus.mem_addr == 16'h002F) && t < 60) begin
      @(negedge clk_sys);
      t++;
    end
    check("rst3_reached", 32'(t < 60), 32'd1);
    exp_write(0, 16'h3000, 8'h77);
    #2 reset = 1'b1;
    #1;
    check("rst3_mem_wr",   32'(bus.mem_wr),   32'd0);
    check("rst3_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst3_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst3_busy",     32'(bus.busy),     32'd0);
    check("rst3_end_addr", 32'(bus.end_addr), 32'd0);
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    repeat (30) @(negedge clk_sys);
    check("rst3_no_writes", 32'(log_addr.size()), 32'd0);

    load_file(8'd1, 1'b0, 64'h001299, 3, 1'b0);
    repeat (40) @(negedge clk_sys);
    check("post_count", 32'(log_addr.size()), 32'd9);
    exp_write(0, 16'h1200, 8'h99);
    exp_inject(1, 16'h1201);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prg_loader.md
# prg_loader

Download-side loader between the SPI data_io stream and the memory write port (SDRAM plus the VIC-20 internal configuration bus). It parses PRG and CRT files as they stream in, strips the 2-byte load-address header, emits one addressed write per payload byte, and, after a PRG download ends, injects the BASIC start/end pointers so `RUN` works immediately. It owns all download sequencing; downstream logic only decodes `mem_addr` to choose the target memory.

## Interface
Parameters:
- `INJECT_GAP`, default 2: clock cycles between successive injected pointer writes (minimum 1).

Ports:
- `clk_sys` in 1: system clock (32 MHz domain).
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: high while a file transfer is in progress.
- `ioctl_index` in 8: file type. `[4:0]` == 1 is PRG; == 2 is CRT; any other value is ignored.
- `ioctl_wr` in 1: single-cycle strobe; the byte is valid on `ioctl_dout` in that cycle.
- `ioctl_addr` in 16: byte offset within the file. Informational only; the block counts bytes itself.
- `ioctl_dout` in 8: file byte.
- `crt_load_addr` in 1: CRT only. 1 means the first two bytes are the load address; 0 means headerless, loaded at $A000.
- `mem_wr` out 1: single-cycle write strobe.
- `mem_addr` out 16: write address.
- `mem_data` out 8: write data.
- `busy` out 1: high from the first accepted byte until injection finishes or the block returns to IDLE.
- `end_addr` out 16: one past the last payload address. Holds its value after the download ends.

## Operation
- States: IDLE, HDR_LO, HDR_HI, DATA, INJECT.
- **IDLE -> start:** on a rising edge of `ioctl_download` with a valid index:
  - PRG, or CRT with `crt_load_addr`=1: go to HDR_LO.
  - CRT with `crt_load_addr`=0: set `ptr`=$A000 and go to DATA.
- **HDR_LO:** the first `ioctl_wr` loads `ptr[7:0]`. Go to HDR_HI.
- **HDR_HI:** the next `ioctl_wr` loads `ptr[15:8]`. Go to DATA.
- **DATA:** each `ioctl_wr` produces `mem_wr`, with `mem_addr`=`ptr` and `mem_data`=`ioctl_dout`, then `ptr` <= `ptr`+1.
  - `ptr` is 16-bit and wraps $FFFF -> $0000.
  - `end_addr` tracks `ptr`.
- **Falling edge of `ioctl_download`:**
  - PRG in DATA: go to INJECT.
  - CRT: go to IDLE.
  - Still in HDR_LO or HDR_HI (file under 2 bytes): go to IDLE with no writes and no injection.
- **INJECT:** 8 writes, in this order: $2D=lo, $2E=hi, $2F=lo, $30=hi, $31=lo, $32=hi, $AE=lo, $AF=hi, where lo/hi are the bytes of `end_addr`. Then go to IDLE.
- `ioctl_wr` while `ioctl_download`=0, or with an invalid index, is ignored.
- A new rising edge of `ioctl_download` during INJECT aborts the remaining injected writes and restarts the parse for the new file.
- A PRG with only the header (2 bytes) still injects, using `end_addr` = load address.

## Timing
- Reset values: `mem_wr`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `end_addr`=0, state=IDLE, `ptr`=0.
- All outputs are registered.
- `mem_wr` asserts exactly 1 cycle after the accepting `ioctl_wr` and stays high for 1 cycle.
- `mem_addr` and `mem_data` are valid in the same cycle as `mem_wr` and hold until the next write.
- Back-to-back `ioctl_wr` on consecutive cycles must be accepted without loss.
- Injection:
  - The first injected `mem_wr` comes 2 cycles after `ioctl_download` falls.
  - Subsequent injected writes come every `INJECT_GAP` cycles.
  - `busy` drops in the cycle after the 8th injected write.
- Rising and falling edges of `ioctl_download` are detected on a 1-cycle registered copy.
- A same-cycle `ioctl_wr` and falling edge: the byte is written first, and injection uses the updated `end_addr`.
- Reset asserted mid-download or mid-inject: all outputs clear immediately, and no further writes are issued until the next rising edge of `ioctl_download` after reset releases.

## Structure
- Package `vic20_loader_pkg` holds:
  - State enum.
  - Index constants `IDX_PRG`=1 and `IDX_CRT`=2.
  - `CRT_DEFAULT_BASE`=$A000.
  - 8-entry constant array of injection addresses, with the lo/hi select bit per entry.
- Optional sub-module `prg_ptr_injector`: a 3-bit index counter and gap counter that emit the injection address, data and strobe. The main FSM arbitrates it onto `mem_*`.

## Test plan
- PRG: bytes 01 10 AA BB CC -> writes $1001=AA, $1002=BB, $1003=CC; `end_addr`=$1004; injection writes $2D=04, $2E=10, … $AF=10; 11 `mem_wr` total.
- CRT, `crt_load_addr`=0: bytes 11 22 -> writes $A000=11, $A001=22; no injection; `busy` low 1 cycle after the end of download.
- CRT, `crt_load_addr`=1: bytes 00 60 55 -> single write $6000=55; no injection.
- Wrap: PRG with header FF FF and bytes 01 02 -> writes $FFFF=01, $0000=02; `end_addr`=$0001; $2D=01, $2E=00.
- Edge cases:
  - 1-byte PRG: zero `mem_wr`.
  - `ioctl_index`=0 download: zero `mem_wr`.
  - Back-to-back `ioctl_wr`: no dropped bytes.
- Async `reset` pulse during the 3rd injected write: outputs are 0 within the same cycle; no further writes; a following PRG download behaves normally.
